dp_ram_sync: RTL
================

// Module: dp_ram_sync
// PURPOSE
//  Parametrised single-clock true dual-port RAM; successor to the fixed 4K9 block RAM primitive.
//  Per-port write mode, per-port output pipeline, read-valid strobes, collision flag, post-reset clear engine.
//  Sits under vs_infrastructure as the buffer for value-store and sample-history memories.
// PARAMETERS
//  DWIDTH     9  data bits per word, both ports
//  AWIDTH     9  address bits; DEPTH = 2**AWIDTH words
//  PIPE_A     0  1 = extra output register on port A
//  PIPE_B     0  1 = extra output register on port B
//  WMODE_A    0  0 = dout holds on write; 1 = write-through (dout = din)
//  WMODE_B    0  same, port B
//  CLEAR_EN   1  1 = clear engine writes CLEAR_VAL to every word after reset
//  CLEAR_VAL  0  DWIDTH-bit fill value
// PORTS
//  clk        in   1       sole clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  init_busy  out  1       high while the clear engine runs; ports ignored
//  a_en       in   1       port A access enable
//  a_we       in   1       port A write (qualified by a_en)
//  a_addr     in   AWIDTH  port A address
//  a_din      in   DWIDTH  port A write data
//  a_dout     out  DWIDTH  port A read data
//  a_dvalid   out  1       one-cycle strobe, a_dout newly valid
//  b_*        --   --      identical set for port B
//  collision  out  1       one-cycle strobe: both ports wrote the same address
// BEHAVIOUR
//  Reset (async assert, sync release): a_dout/b_dout=0, dvalids=0, collision=0, pipe regs=0.
//   init_busy=1 if CLEAR_EN else 0. Array contents are not reset.
//  Clear FSM: IDLE, CLEAR. Reset -> CLEAR (CLEAR_EN=1) or IDLE.
//   CLEAR: writes CLEAR_VAL to addr 0..DEPTH-1, one word/cycle; on the last word -> IDLE,
//   init_busy drops the following cycle. Total DEPTH cycles after reset release.
//   Reset mid-clear restarts at addr 0. en/we are ignored while busy: no writes, no dvalid.
//  Read (en=1, we=0): data registered at edge N; dout/dvalid at N+1 (PIPE=0), N+2 (PIPE=1).
//   dvalid pulses once per accepted read; back-to-back reads give one word per cycle.
//  Write (en=1, we=1): array updated at edge N.
//   WMODE=0: dout holds its last value, no dvalid.
//   WMODE=1: dout=din with dvalid, same latency as a read.
//  en=0: dout holds its value, dvalid=0; the pipe stage shifts only on an accepted access.
//  Same address, both ports writing: port A data stored, B dropped; collision pulses at N+1.
//  Same address, one port reading while the other writes: reader gets OLD data (read-before-write).
//  Same address, both ports reading: both get identical data.
//  Addresses wrap naturally (DEPTH = 2**AWIDTH); no out-of-range case exists.
// STRUCTURE
//  dp_ram_defs.vh: WMODE_HOLD=0, WMODE_THRU=1 constants; clear FSM state encodings.
//  Sub-module dp_ram_port: per-port output register, optional pipe stage, dvalid generation,
//   parametrised by PIPE and WMODE; instantiated twice.
//  Top level holds the array (reg [DWIDTH-1:0] mem[0:DEPTH-1]), write arbitration, clear FSM and counter.
// TESTING
//  1 Reset, CLEAR_EN=1, AWIDTH=9 -> init_busy high exactly 512 cycles; then A reads 0x1FF -> 0x000.
//  2 A writes 0x155 @0x010; B reads 0x010 next cycle -> b_dout=0x155, b_dvalid at +1 (PIPE_B=0) and +2 (PIPE_B=1).
//  3 Same cycle: A writes 0x0AA and B writes 0x111 @0x020 -> collision pulse; a later read of 0x020 returns 0x0AA.
//  4 Word @0x030 = 0x001; same cycle A writes 0x1FE @0x030 while B reads 0x030 -> b_dout=0x001; next read -> 0x1FE.
//  5 WMODE_A=0: A writes 0x0F0 after reading 0x123 -> a_dout stays 0x123, no a_dvalid;
//    WMODE_A=1 -> a_dout=0x0F0 with a_dvalid.
//  6 Assert reset_n low at clear addr 200 -> outputs 0 immediately; on release the clear restarts and busy lasts 512 cycles.

Source files
------------

// File: rtl/dp_ram_sync_pkg.sv
// ----------------------------------------------------------------------------
// dp_ram_sync_pkg
// Shared definitions for the dual-port RAM slice:
//   WMODE_HOLD / WMODE_THRU : per-port write-mode selectors
//   clrState_e              : states of the post-reset clear engine
// ----------------------------------------------------------------------------
package dp_ram_sync_pkg;

    localparam int WMODE_HOLD = 0;
    localparam int WMODE_THRU = 1;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clrState_e;

endpackage

// File: rtl/dp_ram_sync_if.sv
// ----------------------------------------------------------------------------
// dp_ram_sync_if
// Bundles both RAM access ports plus the status strobes.
//   a_en/a_we/a_addr/a_din : port A request      (master -> slave)
//   a_dout/a_dvalid        : port A read return  (slave -> master)
//   b_*                    : identical set for port B
//   collision              : both ports wrote the same address
//   init_busy              : clear engine running, requests ignored
// ----------------------------------------------------------------------------
interface dp_ram_sync_if #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 9
);
    logic              a_en;
    logic              a_we;
    logic [AWIDTH-1:0] a_addr;
    logic [DWIDTH-1:0] a_din;
    logic [DWIDTH-1:0] a_dout;
    logic              a_dvalid;

    logic              b_en;
    logic              b_we;
    logic [AWIDTH-1:0] b_addr;
    logic [DWIDTH-1:0] b_din;
    logic [DWIDTH-1:0] b_dout;
    logic              b_dvalid;

    logic              collision;
    logic              init_busy;

    modport master (
        output a_en, a_we, a_addr, a_din,
        output b_en, b_we, b_addr, b_din,
        input  a_dout, a_dvalid, b_dout, b_dvalid,
        input  collision, init_busy
    );

    modport slave (
        input  a_en, a_we, a_addr, a_din,
        input  b_en, b_we, b_addr, b_din,
        output a_dout, a_dvalid, b_dout, b_dvalid,
        output collision, init_busy
    );
endinterface

// File: rtl/dp_ram_sync_port.sv
// ----------------------------------------------------------------------------
// dp_ram_sync_port
// Output side of one RAM port: output register, optional extra pipe stage
// and the dvalid strobe.
//   clk, reset_n : clock, async active-low reset
//   accept_i     : access accepted this cycle (en and not busy)
//   we_i         : accepted access is a write
//   rdata_i      : array word at the port address (pre-write contents)
//   din_i        : write data, returned on write-through ports
//   dout_o       : registered read data
//   dvalid_o     : one-cycle strobe, dout_o newly valid
// ----------------------------------------------------------------------------
module dp_ram_sync_port
    import dp_ram_sync_pkg::*;
#(
    parameter int DWIDTH = 9,
    parameter int PIPE   = 0,
    parameter int WMODE  = WMODE_HOLD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              accept_i,
    input  logic              we_i,
    input  logic [DWIDTH-1:0] rdata_i,
    input  logic [DWIDTH-1:0] din_i,
    output logic [DWIDTH-1:0] dout_o,
    output logic              dvalid_o
);

    // Reads always return data; writes only do so on write-through ports.
    logic              produce;
    logic [DWIDTH-1:0] srcData;
    logic              feedValid;
    logic [DWIDTH-1:0] feedData;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;

    assign produce = accept_i && (!we_i || (WMODE == WMODE_THRU));
    assign srcData = we_i ? din_i : rdata_i;

    generate
        if (PIPE != 0) begin : g_pipe
            logic [DWIDTH-1:0] stgData_q;
            logic              stgValid_q;

            // The stage only loads on a producing access, so idle cycles
            // never overwrite a word still on its way out.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stgData_q  <= '0;
                    stgValid_q <= 1'b0;
                end else begin
                    stgValid_q <= produce;
                    if (produce) begin
                        stgData_q <= srcData;
                    end
                end
            end

            assign feedValid = stgValid_q;
            assign feedData  = stgData_q;
        end else begin : g_direct
            assign feedValid = produce;
            assign feedData  = srcData;
        end
    endgenerate

    // dout holds whenever nothing new arrives.
    always_comb begin
        dvalid_d = feedValid;
        dout_d   = feedValid ? feedData : dout_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign dout_o   = dout_q;
    assign dvalid_o = dvalid_q;

endmodule

// File: rtl/dp_ram_sync.sv
// ----------------------------------------------------------------------------
// dp_ram_sync
// Single-clock true dual-port RAM with per-port write mode and output pipe,
// read-valid strobes, write-collision flag and a post-reset clear engine.
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : dp_ram_sync_if slave (both ports, collision, init_busy)
// ----------------------------------------------------------------------------
module dp_ram_sync
    import dp_ram_sync_pkg::*;
#(
    parameter int              DWIDTH    = 9,
    parameter int              AWIDTH    = 9,
    parameter int              PIPE_A    = 0,
    parameter int              PIPE_B    = 0,
    parameter int              WMODE_A   = WMODE_HOLD,
    parameter int              WMODE_B   = WMODE_HOLD,
    parameter int              CLEAR_EN  = 1,
    parameter logic [DWIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    dp_ram_sync_if.slave bus
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    clrState_e         state_q, state_d;
    logic [AWIDTH-1:0] clrAddr_q, clrAddr_d;
    logic              busy;
    logic              aAcc, bAcc, aWr, bWr, sameAddr;
    logic              collision_q, collision_d;
    logic [DWIDTH-1:0] aRdata, bRdata;

    assign busy     = (state_q == CLR_RUN);
    assign aAcc     = bus.a_en && !busy;
    assign bAcc     = bus.b_en && !busy;
    assign aWr      = aAcc && bus.a_we;
    assign bWr      = bAcc && bus.b_we;
    assign sameAddr = (bus.a_addr == bus.b_addr);

    // Combinational view of the array; sampled by the port registers at the
    // same edge the write lands, which gives read-before-write behaviour.
    assign aRdata = mem[bus.a_addr];
    assign bRdata = mem[bus.b_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= (CLEAR_EN != 0) ? CLR_RUN : CLR_IDLE;
            clrAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
        end
    end

    // Clear engine: one word per cycle, leaves after writing the top address.
    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        if (state_q == CLR_RUN) begin
            clrAddr_d = clrAddr_q + 1'b1;
            if (clrAddr_q == {AWIDTH{1'b1}}) begin
                state_d = CLR_IDLE;
            end
        end
    end

    // Port A wins a same-address double write; B's data is dropped.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clrAddr_q] <= CLEAR_VAL;
        end else begin
            if (aWr) begin
                mem[bus.a_addr] <= bus.a_din;
            end
            if (bWr && !(aWr && sameAddr)) begin
                mem[bus.b_addr] <= bus.b_din;
            end
        end
    end

    assign collision_d = aWr && bWr && sameAddr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    dp_ram_sync_port #(
        .DWIDTH (DWIDTH),
        .PIPE   (PIPE_A),
        .WMODE  (WMODE_A)
    ) u_portA (
        .clk      (clk),
        .reset_n  (reset_n),
        .accept_i (aAcc),
        .we_i     (bus.a_we),
        .rdata_i  (aRdata),
        .din_i    (bus.a_din),
        .dout_o   (bus.a_dout),
        .dvalid_o (bus.a_dvalid)
    );

    dp_ram_sync_port #(
        .DWIDTH (DWIDTH),
        .PIPE   (PIPE_B),
        .WMODE  (WMODE_B)
    ) u_portB (
        .clk      (clk),
        .reset_n  (reset_n),
        .accept_i (bAcc),
        .we_i     (bus.b_we),
        .rdata_i  (bRdata),
        .din_i    (bus.b_din),
        .dout_o   (bus.b_dout),
        .dvalid_o (bus.b_dvalid)
    );

    assign bus.collision = collision_q;
    assign bus.init_busy = busy;

endmodule
